regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Write-port arbiter and scheduler for the 32×32 register file. The register file has one write port (`rd`/`writedata`/`regwrite`). This block shares that port between two requesters: the MEM/WB writeback stage and a multi-cycle execution unit (mul/div). The multi-cycle unit is buffered in a small FIFO. Fixed priority goes to writeback, with a starvation guard. The block also tells the hazard unit which registers have buffered writes pending.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width
- `DEPTH`, 2, multi-cycle FIFO entries (power of 2, ≥2)
- `STARVE_MAX`, 4, consecutive writeback grants allowed while the FIFO is non-empty before a forced FIFO grant

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `wb_valid`  in  1  MEM/WB has a register write this cycle
- `wb_rd`  in  ADDR_W  MEM/WB destination
- `wb_data`  in  DATA_W  MEM/WB write data
- `wb_stall`  out  1  writeback not granted this cycle; the pipeline holds MEM/WB (combinational)
- `mc_valid`  in  1  multi-cycle unit offers a result
- `mc_ready`  out  1  FIFO can accept (= !full)
- `mc_rd`  in  ADDR_W  multi-cycle destination
- `mc_data`  in  DATA_W  multi-cycle result
- `chk_rs`, `chk_rt`, `chk_rd`  in  ADDR_W  decode-stage indices to check
- `hazard`  out  1  a non-zero `chk_*` matches a valid FIFO entry's rd (combinational)
- `rf_regwrite`  out  1  to register file `regwrite` (registered)
- `rf_rd`  out  ADDR_W  to register file `rd` (registered)
- `rf_data`  out  DATA_W  to register file `writedata` (registered)

## Operation
- FSM states:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, starvation counter running.
  - FORCE: one cycle; a FIFO grant is forced.
- Push:
  - A push happens when `mc_valid && mc_ready`.
  - `mc_ready` is low when full. There is no bypass of a full FIFO, even if the FIFO pops in the same cycle.
- Grant, evaluated each cycle:
  - In IDLE or PEND, with `wb_valid` and `wb_rd != 0`: grant writeback.
  - Otherwise, if the FIFO is non-empty: pop the head.
  - Otherwise: no write.
  - In FORCE: pop the head and assert `wb_stall` if `wb_valid`.
- The register file never receives a write to r0:
  - Writeback with rd 0 is consumed (not stalled) and not written.
  - A FIFO head with rd 0 is popped without a write.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments in PEND each cycle writeback is granted.
  - Cleared on any pop and in IDLE.
- Transitions:
  - IDLE→PEND on a push.
  - PEND→FORCE when the counter reaches STARVE_MAX.
  - FORCE→PEND if entries remain after the pop; otherwise FORCE→IDLE.
  - PEND→IDLE when the last entry pops with no simultaneous push.
- Ordering:
  - Writes reach the register file in grant order.
  - WAW and RAW safety against pending multi-cycle results comes from `hazard`. Decode must stall while it is high.
  - `hazard` ignores index 0.

## Timing
- Reset values:
  - State IDLE, counter 0, FIFO empty.
  - `rf_regwrite`=0, `rf_rd`=0, `rf_data`=0.
  - `mc_ready`=1, `hazard`=0, `wb_stall`=0.
- Latency:
  - The grant decision is made in cycle N. `rf_*` are valid in cycle N+1, registered.
  - The register file updates combinationally from `rf_*`.
- A pushed entry can be granted, at earliest, in the cycle after the push. Minimum write latency from `mc_valid` to `rf_regwrite` is 2 cycles.
- `hazard` covers an entry from the cycle after its push until the cycle of its pop, inclusive.
- Same-cycle push and pop when non-full: both occur; occupancy is unchanged.
- Asynchronous reset mid-operation discards FIFO contents and any registered write; `rf_regwrite` drops immediately.

## Structure
- Shared package `rf_pkg`:
  - DATA_W, ADDR_W constants.
  - FSM state enum (IDLE, PEND, FORCE).
  - Write-request struct {rd, data}.
- Sub-module `rf_wr_fifo`:
  - Parameterised DEPTH FIFO with full/empty.
  - Per-entry valid+rd vector exported for the hazard comparators.
- Top level holds the FSM, counter, grant mux and output registers.

## Test plan
- Reset with `mc_valid`=1 and `wb_valid`=1 asserted → all outputs at reset values; first write appears 2 cycles after `rst_n` rises.
- Push mc rd=5 data=0xAB with `wb_valid`=0 → `rf_regwrite`=1, rd=5, data=0xAB two cycles after the push; `hazard` high for `chk_rs`=5 until the pop.
- Push mc rd=7, then `wb_valid`=1 rd=3 every cycle:
  - Writeback is granted 4 times.
  - 5th cycle: FORCE, `wb_stall`=1, rd=7 is written.
  - rd=3 is written the following cycle.
- Fill the FIFO (2 pushes, `wb_valid` held with rd≠0) → `mc_ready`=0. A third `mc_valid` is held until the pop; no entry is lost or duplicated.
- `wb_rd`=0 and mc rd=0 → no `rf_regwrite` is ever asserted; `wb_stall`=0; `hazard`=0 for `chk_rt`=0.
- Assert `rst_n`=0 with 2 entries pending → `mc_ready`=1, `hazard`=0 immediately; no pending write ever reaches the register file.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port arbiter:
//   - DATA_W / ADDR_W : register data width and register index width
//   - arb_state_t     : arbiter FSM states (IDLE, PEND, FORCE)
//   - wr_req_t        : one register write request {rd, data}
//   - idx_match()     : hazard comparator that never matches index 0
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // r0 is hard-wired to zero, so a decode index of 0 can never be a hazard.
    function automatic logic idx_match(input logic [ADDR_W-1:0] chk_idx,
                                       input logic [ADDR_W-1:0] ent_idx);
        return (chk_idx != {ADDR_W{1'b0}}) && (chk_idx == ent_idx);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles the arbiter's pipeline-facing signals:
//   writeback : wb_valid, wb_rd, wb_data -> wb_stall
//   mul/div   : mc_valid, mc_rd, mc_data -> mc_ready
//   hazard    : chk_rs, chk_rt, chk_rd   -> hazard
//   reg file  : rf_regwrite, rf_rd, rf_data
// modport slave  : the arbiter
// modport master : the surrounding pipeline / register file
// ---------------------------------------------------------------------------
interface regfile_wr_arbiter_if
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;

    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_rd;
    logic [DATA_W-1:0] mc_data;

    logic [ADDR_W-1:0] chk_rs;
    logic [ADDR_W-1:0] chk_rt;
    logic [ADDR_W-1:0] chk_rd;
    logic              hazard;

    logic              rf_regwrite;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;

    modport slave (
        input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
               chk_rs, chk_rt, chk_rd,
        output wb_stall, mc_ready, hazard, rf_regwrite, rf_rd, rf_data
    );

    modport master (
        output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
               chk_rs, chk_rt, chk_rd,
        input  wb_stall, mc_ready, hazard, rf_regwrite, rf_rd, rf_data
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// ---------------------------------------------------------------------------
// rf_wr_fifo
// DEPTH-entry FIFO of pending multi-cycle register writes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_req    : write push_req at the tail (ignored when full)
//   pop               : drop the head (ignored when empty)
//   head              : current head entry
//   full, empty, cnt  : occupancy status
//   ent_valid, ent_rd : per-slot valid bit and destination, for hazard checks
// ---------------------------------------------------------------------------
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  wr_req_t                         push_req,
    input  logic                            pop,
    output wr_req_t                         head,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH+1)-1:0]      cnt,
    output logic [DEPTH-1:0]                ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]    ent_rd
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_req_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DEPTH-1:0]   valid_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign empty     = (cnt_r == {CNT_W{1'b0}});
    assign cnt       = cnt_r;
    assign ent_valid = valid_r;
    assign head      = mem_r[rd_ptr_r];

    // Push only into a free slot and pop only an occupied one, so the push
    // slot and the pop slot can never coincide in the same cycle.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_rd[g] = mem_r[g].rd;
    end

    // Storage, pointers, per-slot valid bits and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{rd: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r]   <= push_req;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the register file's single write port between MEM/WB writeback and
// a buffered multi-cycle (mul/div) unit. Writeback has fixed priority; after
// STARVE_MAX consecutive writeback grants with results waiting, one FIFO
// grant is forced and writeback is stalled. Writes to r0 are dropped.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipeline-facing signals (regfile_wr_arbiter_if.slave)
//           wb_stall, mc_ready, hazard are combinational; rf_* are registered
// DATA_W / ADDR_W must equal the rf_pkg constants used by the write struct.
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W     = rf_pkg::DATA_W,
    parameter int ADDR_W     = rf_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam int FCNT_W = $clog2(DEPTH + 1);

    arb_state_t                 state_r;
    logic [SCNT_W-1:0]          starve_r;
    logic                       rf_regwrite_r;
    logic [ADDR_W-1:0]          rf_rd_r;
    logic [DATA_W-1:0]          rf_data_r;

    wr_req_t                    push_req_s;
    wr_req_t                    head_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [FCNT_W-1:0]          fifo_cnt_s;
    logic [DEPTH-1:0]           ent_valid_s;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd_s;
    logic [DEPTH-1:0]           hit_s;

    logic                       wb_req_s;
    logic                       forced_s;
    logic                       wb_grant_s;
    logic                       wr_en_s;
    logic [ADDR_W-1:0]          nxt_rd_s;
    logic [DATA_W-1:0]          nxt_data_s;
    logic                       last_pop_s;

    // No bypass: a full FIFO refuses a push even if it pops this cycle.
    assign push_s          = bus.mc_valid && !fifo_full_s;
    assign push_req_s.rd   = bus.mc_rd;
    assign push_req_s.data = bus.mc_data;

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_req  (push_req_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .cnt       (fifo_cnt_s),
        .ent_valid (ent_valid_s),
        .ent_rd    (ent_rd_s)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_haz
        assign hit_s[g] = ent_valid_s[g] &&
                          (idx_match(bus.chk_rs, ent_rd_s[g]) ||
                           idx_match(bus.chk_rt, ent_rd_s[g]) ||
                           idx_match(bus.chk_rd, ent_rd_s[g]));
    end

    // Grant decision: writeback first unless a FIFO grant is being forced.
    // A writeback to r0 never requests the port, so it is consumed silently
    // and the FIFO head may use the port in the same cycle.
    always_comb begin
        wb_req_s   = bus.wb_valid && (bus.wb_rd != {ADDR_W{1'b0}});
        forced_s   = (state_r == FORCE);
        wb_grant_s = 1'b0;
        pop_s      = 1'b0;
        wr_en_s    = 1'b0;
        nxt_rd_s   = {ADDR_W{1'b0}};
        nxt_data_s = {DATA_W{1'b0}};
        if (wb_req_s && !forced_s) begin
            wb_grant_s = 1'b1;
            wr_en_s    = 1'b1;
            nxt_rd_s   = bus.wb_rd;
            nxt_data_s = bus.wb_data;
        end else if (!fifo_empty_s) begin
            pop_s = 1'b1;
            if (head_s.rd != {ADDR_W{1'b0}}) begin
                wr_en_s    = 1'b1;
                nxt_rd_s   = head_s.rd;
                nxt_data_s = head_s.data;
            end else begin
                wr_en_s    = 1'b0;
            end
        end else begin
            wb_grant_s = 1'b0;
        end
    end

    // FIFO empties this cycle: the only entry leaves and nothing replaces it.
    assign last_pop_s = pop_s && (fifo_cnt_s == FCNT_W'(1)) && !push_s;

    // Arbiter FSM, starvation counter and registered register-file port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            starve_r      <= {SCNT_W{1'b0}};
            rf_regwrite_r <= 1'b0;
            rf_rd_r       <= {ADDR_W{1'b0}};
            rf_data_r     <= {DATA_W{1'b0}};
        end else begin
            rf_regwrite_r <= wr_en_s;
            rf_rd_r       <= nxt_rd_s;
            rf_data_r     <= nxt_data_s;
            case (state_r)
                IDLE: begin
                    starve_r <= {SCNT_W{1'b0}};
                    if (push_s) begin
                        state_r <= PEND;
                    end
                end
                PEND: begin
                    if (wb_grant_s) begin
                        starve_r <= starve_r + SCNT_W'(1);
                        if (starve_r == SCNT_W'(STARVE_MAX - 1)) begin
                            state_r <= FORCE;
                        end
                    end else if (pop_s) begin
                        starve_r <= {SCNT_W{1'b0}};
                        if (last_pop_s) begin
                            state_r <= IDLE;
                        end
                    end
                end
                FORCE: begin
                    starve_r <= {SCNT_W{1'b0}};
                    state_r  <= last_pop_s ? IDLE : PEND;
                end
                default: begin
                    starve_r <= {SCNT_W{1'b0}};
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_stall    = forced_s && wb_req_s;
    assign bus.mc_ready    = !fifo_full_s;
    assign bus.hazard      = |hit_s;
    assign bus.rf_regwrite = rf_regwrite_r;
    assign bus.rf_rd       = rf_rd_r;
    assign bus.rf_data     = rf_data_r;

endmodule
